// File: rtl/reservation_station.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reservation_station: holds renamed ops until both operands are ready,     |
// | then issues them oldest-first to one functional unit.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module reservation_station #(
   parameter int RS_SIZE = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 3,
   parameter int FUNC_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [FUNC_W-1:0] in_func,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [TAG_W-1:0]  in_tag_dest,
   input  logic [TAG_W-1:0]  in_tag_src1,
   input  logic [TAG_W-1:0]  in_tag_src2,
   input  logic              in_ready_src1,
   input  logic              in_ready_src2,
   input  logic [XLEN-1:0]   in_value_src1,
   input  logic [XLEN-1:0]   in_value_src2,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [XLEN-1:0]   cdb_value,
   input  logic              flush,
   input  logic              fu_ready,
   output logic              is_full,
   output logic              issue_valid,
   output logic [FUNC_W-1:0] issue_func,
   output logic [XLEN-1:0]   issue_imm,
   output logic [XLEN-1:0]   issue_pc,
   output logic [TAG_W-1:0]  issue_tag_dest,
   output logic [XLEN-1:0]   issue_value_src1,
   output logic [XLEN-1:0]   issue_value_src2
);

   localparam int AW = $clog2(RS_SIZE);
   localparam int CW = AW + 1;

   logic [RS_SIZE-1:0] r_valid;
   logic [RS_SIZE-1:0] r_rdy1;
   logic [RS_SIZE-1:0] r_rdy2;
   logic [FUNC_W-1:0]  r_func [RS_SIZE];
   logic [XLEN-1:0]    r_imm  [RS_SIZE];
   logic [XLEN-1:0]    r_pc   [RS_SIZE];
   logic [TAG_W-1:0]   r_tagd [RS_SIZE];
   logic [TAG_W-1:0]   r_tag1 [RS_SIZE];
   logic [TAG_W-1:0]   r_tag2 [RS_SIZE];
   logic [XLEN-1:0]    r_val1 [RS_SIZE];
   logic [XLEN-1:0]    r_val2 [RS_SIZE];
   logic [AW-1:0]      r_age  [RS_SIZE];

   logic              r_issue_valid;
   logic [FUNC_W-1:0] r_issue_func;
   logic [XLEN-1:0]   r_issue_imm;
   logic [XLEN-1:0]   r_issue_pc;
   logic [TAG_W-1:0]  r_issue_tagd;
   logic [XLEN-1:0]   r_issue_val1;
   logic [XLEN-1:0]   r_issue_val2;

   logic [CW-1:0]   w_count;
   logic            w_found;
   logic [AW-1:0]   w_sel_idx;
   logic [AW-1:0]   w_sel_age;
   logic [AW-1:0]   w_free_idx;
   logic            w_out_load;
   logic            w_remove;
   logic            w_insert;
   logic [AW-1:0]   w_new_age;
   logic            w_byp1;
   logic            w_byp2;

   // Selection uses registered state only, so a wakeup takes effect next cycle.
   always_comb begin
      w_count    = '0;
      w_found    = 1'b0;
      w_sel_idx  = '0;
      w_sel_age  = '0;
      w_free_idx = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         w_count = w_count + CW'(r_valid[i]);
         if (r_valid[i] && r_rdy1[i] && r_rdy2[i] && (!w_found || r_age[i] < w_sel_age)) begin
            w_found   = 1'b1;
            w_sel_idx = AW'(i);
            w_sel_age = r_age[i];
         end
      end
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = AW'(i);
      end
      w_out_load = !r_issue_valid || fu_ready;
      w_remove   = w_out_load && w_found;
      w_insert   = load && !is_full;
      w_new_age  = AW'(w_count - CW'(w_remove));
      w_byp1     = cdb_valid && !in_ready_src1 && (cdb_tag == in_tag_src1);
      w_byp2     = cdb_valid && !in_ready_src2 && (cdb_tag == in_tag_src2);
   end

   assign is_full = (w_count == CW'(RS_SIZE));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid       <= '0;
         r_rdy1        <= '0;
         r_rdy2        <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            r_func[i] <= '0;
            r_imm[i]  <= '0;
            r_pc[i]   <= '0;
            r_tagd[i] <= '0;
            r_tag1[i] <= '0;
            r_tag2[i] <= '0;
            r_val1[i] <= '0;
            r_val2[i] <= '0;
            r_age[i]  <= '0;
         end
         r_issue_valid <= 1'b0;
         r_issue_func  <= '0;
         r_issue_imm   <= '0;
         r_issue_pc    <= '0;
         r_issue_tagd  <= '0;
         r_issue_val1  <= '0;
         r_issue_val2  <= '0;
      end else if (flush) begin
         r_valid       <= '0;
         r_issue_valid <= 1'b0;
         for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (cdb_valid && r_valid[i]) begin
               if (!r_rdy1[i] && r_tag1[i] == cdb_tag) begin
                  r_rdy1[i] <= 1'b1;
                  r_val1[i] <= cdb_value;
               end
               if (!r_rdy2[i] && r_tag2[i] == cdb_tag) begin
                  r_rdy2[i] <= 1'b1;
                  r_val2[i] <= cdb_value;
               end
            end
            // Keep ages dense: everything younger than the issued entry moves up.
            if (w_remove && r_valid[i] && r_age[i] > w_sel_age)
               r_age[i] <= r_age[i] - AW'(1);
         end
         if (w_remove) r_valid[w_sel_idx] <= 1'b0;
         if (w_insert) begin
            r_valid[w_free_idx] <= 1'b1;
            r_func[w_free_idx]  <= in_func;
            r_imm[w_free_idx]   <= in_imm;
            r_pc[w_free_idx]    <= in_pc;
            r_tagd[w_free_idx]  <= in_tag_dest;
            r_tag1[w_free_idx]  <= in_tag_src1;
            r_tag2[w_free_idx]  <= in_tag_src2;
            r_rdy1[w_free_idx]  <= in_ready_src1 || w_byp1;
            r_rdy2[w_free_idx]  <= in_ready_src2 || w_byp2;
            r_val1[w_free_idx]  <= w_byp1 ? cdb_value : in_value_src1;
            r_val2[w_free_idx]  <= w_byp2 ? cdb_value : in_value_src2;
            r_age[w_free_idx]   <= w_new_age;
         end
         if (w_out_load) begin
            r_issue_valid <= w_found;
            if (w_found) begin
               r_issue_func <= r_func[w_sel_idx];
               r_issue_imm  <= r_imm[w_sel_idx];
               r_issue_pc   <= r_pc[w_sel_idx];
               r_issue_tagd <= r_tagd[w_sel_idx];
               r_issue_val1 <= r_val1[w_sel_idx];
               r_issue_val2 <= r_val2[w_sel_idx];
            end
         end
      end
   end

   assign issue_valid      = r_issue_valid;
   assign issue_func       = r_issue_func;
   assign issue_imm        = r_issue_imm;
   assign issue_pc         = r_issue_pc;
   assign issue_tag_dest   = r_issue_tagd;
   assign issue_value_src1 = r_issue_val1;
   assign issue_value_src2 = r_issue_val2;

endmodule
`default_nettype wire

// File: doc/reservation_station.md
# reservation_station

Holds renamed instructions dispatched for one functional-unit class until both source operands are available, then issues them oldest-first to that functional unit. Sits directly downstream of the dispatcher: it accepts one dispatcher packet per cycle on its `RS_load` bit, reports fullness back on `RS_is_full`, and captures operand values broadcast on the CDB. One instance exists per RS/FU pair; the dispatcher drives four of them.

## Interface

Parameters:
- `RS_SIZE`, 4: number of entries; power of two, at least 2.
- `XLEN`, 32: data width.
- `TAG_W`, 3: ROB tag width.
- `FUNC_W`, 4: function-code width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. `reset==0` at a rising edge clears all state.
- `load` in 1: the dispatcher's `RS_load` bit for this RS. Write the `in_*` packet this cycle.
- `in_func` in FUNC_W: operation code.
- `in_imm`, `in_pc` in XLEN: immediate and PC.
- `in_tag_dest` in TAG_W: ROB tag of the result.
- `in_tag_src1`, `in_tag_src2` in TAG_W: producer tags for the sources.
- `in_ready_src1`, `in_ready_src2` in 1: the corresponding value is valid.
- `in_value_src1`, `in_value_src2` in XLEN: source values.
- `cdb_valid` in 1, `cdb_tag` in TAG_W, `cdb_value` in XLEN: CDB broadcast.
- `flush` in 1: squash everything (branch mispredict).
- `fu_ready` in 1: the FU accepts the issue packet this cycle.
- `is_full` out 1: all entries valid. Feeds the dispatcher's `RS_is_full`.
- `issue_valid` out 1: the issue packet is valid.
- `issue_func`, `issue_imm`, `issue_pc`, `issue_tag_dest`, `issue_value_src1`, `issue_value_src2` out: issue packet, registered.

## Operation

- Each entry holds: `valid`, the packet fields, `ready1/ready2`, `value1/value2`, `tag1/tag2`, and `age` (log2(RS_SIZE) bits; 0 = oldest).
- **Insert:** on `load` with `!is_full`, write the lowest-index free entry.
  - `age` = number of valid entries remaining after this cycle's removal.
  - A `load` while `is_full` is dropped. The bench flags it as a protocol error.
- **Wakeup:** on `cdb_valid`, every valid entry with `readyN==0 && tagN==cdb_tag` sets `readyN=1` and `valueN=cdb_value`.
  - The same comparison applies to the packet being inserted that cycle (CDB-to-insert bypass), so no broadcast is lost.
- **Eligibility:** an entry is eligible when `valid && ready1 && ready2`, using registered state only.
  - A wakeup in cycle t makes the entry eligible in cycle t+1.
- **Select:** among eligible entries, pick the one with minimum `age`.
- **Issue:** the output register loads when `!issue_valid || fu_ready`.
  - If an entry is selected, copy its fields into the output register, set `issue_valid=1`, and free the entry.
  - If no entry is selected, `issue_valid` becomes 0.
  - If the output register is stalled (`issue_valid && !fu_ready`), nothing is removed and the packet holds stable.
- **Age compaction:** when an entry of age r is removed, every remaining entry with age > r decrements by 1. Ages of valid entries are always a permutation of 0..count-1.
- **Flush:** clears every `valid`, `issue_valid`, and all ages. It has priority over load, wakeup and issue in the same cycle.
- **`is_full`:** combinational, `count == RS_SIZE` on registered state. An issue in the same cycle does not lower it until the next cycle.

## Timing

- **Reset:** `issue_valid=0`, `is_full=0`, all `issue_*` fields 0, all entries invalid. Reset has priority over flush.
- **Load to issue:** minimum 2 cycles.
  - `load` with both sources ready in cycle 0.
  - Entry is eligible in cycle 1.
  - `issue_valid=1` in cycle 2.
- **CDB to issue:** minimum 2 cycles. Broadcast in cycle t gives `issue_valid` in cycle t+2.
- **Throughput:** one issue per cycle while `fu_ready` stays high and eligible entries exist.
- **Simultaneous insert and issue:** both occur. The new entry's age accounts for the removal.
- **Reset or flush mid-stall:** the held issue packet is discarded with no handshake.
- **Tag collisions:** two entries may wait on the same tag; one broadcast wakes both.

## Test plan

- **Basic issue:** reset, then `load` func=3 with src1=5 and src2=7 both ready, `fu_ready=1` -> `issue_valid` in cycle 2 with values 5/7 and `is_full` 0 throughout.
- **Wakeup:** load an entry with src1 waiting on tag 2, then `cdb_valid` tag=2 value=0xAB two cycles later -> issue 2 cycles after the broadcast with `issue_value_src1=0xAB`. A broadcast with tag 3 must not wake it.
- **Bypass:** `load` with src2 waiting on tag 4 while `cdb_valid` tag=4 value=9 in the same cycle -> issue 2 cycles later with `value_src2=9`.
- **Oldest-first:** fill 4 entries with tags D0..D3 all waiting on tag 1, then broadcast tag 1 -> issue order D0, D1, D2, D3 on consecutive cycles.
  - `is_full` is 1 while all 4 are valid.
  - A `load` attempted while full is dropped and no fifth packet ever issues.
- **Backpressure:** hold `fu_ready=0` for 3 cycles with `issue_valid=1` -> packet stable and no entry freed; on `fu_ready=1` the next-oldest appears the following cycle.
- **Flush and reset:** `flush` with 3 valid entries plus a stalled issue packet -> next cycle `issue_valid=0`, `is_full=0`, and nothing issues afterward. Repeat with `reset=0` mid-wakeup -> same result.
